// File: rtl/pc_unit_pkg.sv
// Shared next-PC mode codes and default vectors for the program counter unit.
package pc_unit_pkg;

  // Next-PC selection modes driven by the decoder.
  typedef enum logic [1:0] {
    PC_ADDR_NORMAL = 2'b00,
    PC_ADDR_BRANCH = 2'b01,
    PC_ADDR_JUMP   = 2'b10,
    PC_ADDR_RETURN = 2'b11
  } pc_inc_e;

  // Fetch target used when an exception is taken.
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0040;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: the newest entry overwrites the oldest when full.
module pc_ras
  import pc_unit_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  assign ptr_inc  = ptr_q + 1'b1;
  assign top_data = mem_q[ptr_q];
  assign empty    = (cnt_q == '0);
  assign overflow = ovf_q;

  // Pointer/count/overflow update: push saturates the count, pop unwinds it.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      ptr_d = ptr_inc;
      if (cnt_q == FULL_CNT) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack state and storage; a push writes the slot the pointer advances onto.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (push) begin
        mem_q[ptr_inc] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with reset vector, stall, exception/ERET redirect and a return-address stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR),
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              stall,
  input  logic [1:0]        pc_inc_type,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] abs_addr,
  input  logic              is_call,
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] current_pc,
  output logic [ADDR_W-1:0] epc,
  output logic              ras_empty,
  output logic              ras_overflow
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop;

  assign pc_plus1   = pc_q + 1'b1;
  assign current_pc = pc_q;
  assign epc        = epc_q;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .clr_n    (clr_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_plus1),
    .top_data (ras_top),
    .empty    (ras_empty),
    .overflow (ras_overflow)
  );

  // Next-PC selection: exception beats ERET beats stall beats the normal modes.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (exc_req) begin
      epc_d = pc_q;
      pc_d  = EXC_VECTOR;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (!stall) begin
      case (pc_inc_e'(pc_inc_type))
        PC_ADDR_NORMAL: pc_d = pc_plus1;
        PC_ADDR_BRANCH: pc_d = branch_taken ? (pc_plus1 + branch_offset) : pc_plus1;
        PC_ADDR_JUMP: begin
          pc_d     = abs_addr;
          ras_push = is_call;
        end
        PC_ADDR_RETURN: begin
          if (!ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d = abs_addr;
          end
        end
      endcase
    end
  end

  // PC and EPC registers, updated on the falling edge.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expected PCs are queued when driven and checked after the update edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        stall;
  logic [1:0]  pc_inc_type;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] abs_addr;
  logic        is_call;
  logic        exc_req;
  logic        eret;
  logic [31:0] current_pc;
  logic [31:0] epc;
  logic        ras_empty;
  logic        ras_overflow;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ [$];
  logic [31:0] exp;

  pc_unit #(
    .ADDR_W    (32),
    .RESET_PC  (32'h100),
    .EXC_VECTOR(32'h40),
    .RAS_DEPTH (4)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .stall        (stall),
    .pc_inc_type  (pc_inc_type),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .abs_addr     (abs_addr),
    .is_call      (is_call),
    .exc_req      (exc_req),
    .eret         (eret),
    .current_pc   (current_pc),
    .epc          (epc),
    .ras_empty    (ras_empty),
    .ras_overflow (ras_overflow)
  );

  // Free-running clock; the DUT updates on the falling edge.
  always #5 clk = ~clk;

  // Drive one cycle of inputs at a rising edge, queue the expected PC, and return at the next rising edge.
  task automatic cycle(input logic [1:0] t, input logic tk, input logic [31:0] off,
                       input logic [31:0] abs, input logic call, input logic stl,
                       input logic exc, input logic er, input logic [31:0] exp_pc);
    pc_inc_type   = t;
    branch_taken  = tk;
    branch_offset = off;
    abs_addr      = abs;
    is_call       = call;
    stall         = stl;
    exc_req       = exc;
    eret          = er;
    expQ.push_back(exp_pc);
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset();
    clr_n = 1'b1;
    cycle(2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    void'(expQ.pop_front());
    #2 clr_n = 1'b0;
    #1;
    checks++; if (current_pc !== 32'h100) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", current_pc, 32'h100); end
    checks++; if (epc !== 32'h0) begin failures++; $display("[TB] FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", ras_empty); end
    checks++; if (ras_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", ras_overflow); end
    @(posedge clk);
    clr_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle(2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h100 + 32'(i));
      exp = expQ.pop_front();
      checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL reset_seq got=%h exp=%h", current_pc, exp); end
    end
  endtask

  task automatic test_branch();
    cycle(2'b10, 0, 0, 32'h20, 0, 0, 0, 0, 32'h20);
    void'(expQ.pop_front());
    cycle(2'b01, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h1D);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL branch_taken got=%h exp=%h", current_pc, exp); end
    cycle(2'b10, 0, 0, 32'h20, 0, 0, 0, 0, 32'h20);
    void'(expQ.pop_front());
    cycle(2'b01, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h21);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL branch_not_taken got=%h exp=%h", current_pc, exp); end
    cycle(2'b10, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL jump_allones got=%h exp=%h", current_pc, exp); end
    cycle(2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL wrap got=%h exp=%h", current_pc, exp); end
  endtask

  task automatic test_call_return();
    cycle(2'b10, 0, 0, 32'h10, 0, 0, 0, 0, 32'h10);
    void'(expQ.pop_front());
    cycle(2'b10, 0, 0, 32'h80, 1, 0, 0, 0, 32'h80);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL call_pc got=%h exp=%h", current_pc, exp); end
    checks++; if (ras_empty !== 1'b0) begin failures++; $display("[TB] FAIL call_empty got=%b exp=0", ras_empty); end
    cycle(2'b11, 0, 0, 32'h0, 0, 0, 0, 0, 32'h11);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL ret_pc got=%h exp=%h", current_pc, exp); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL ret_empty got=%b exp=1", ras_empty); end
    cycle(2'b11, 0, 0, 32'h55, 0, 0, 0, 0, 32'h55);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL ret_empty_fallback got=%h exp=%h", current_pc, exp); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL ret_empty_stays got=%b exp=1", ras_empty); end
  endtask

  task automatic test_ras_overflow();
    cycle(2'b10, 0, 0, 32'h200, 0, 0, 0, 0, 32'h200);
    void'(expQ.pop_front());
    for (int i = 0; i < 5; i++) begin
      cycle(2'b10, 0, 0, 32'h300 + 32'(i) * 32'h100, 1, 0, 0, 0, 32'h300 + 32'(i) * 32'h100);
      exp = expQ.pop_front();
      checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL nest_call got=%h exp=%h", current_pc, exp); end
      if (i == 3) begin
        checks++; if (ras_overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_no_ovf got=%b exp=0", ras_overflow); end
      end
    end
    checks++; if (ras_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%b exp=1", ras_overflow); end
    for (int j = 0; j < 4; j++) begin
      cycle(2'b11, 0, 0, 32'hDEAD, 0, 0, 0, 0, 32'h601 - 32'(j) * 32'h100);
      exp = expQ.pop_front();
      checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL nest_ret got=%h exp=%h", current_pc, exp); end
    end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty got=%b exp=1", ras_empty); end
    checks++; if (ras_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", ras_overflow); end
  endtask

  task automatic test_stall();
    cycle(2'b10, 0, 0, 32'h30, 0, 0, 0, 0, 32'h30);
    void'(expQ.pop_front());
    cycle(2'b10, 0, 0, 32'h90, 1, 1, 0, 0, 32'h30);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL stall_pc got=%h exp=%h", current_pc, exp); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL stall_no_push got=%b exp=1", ras_empty); end
    cycle(2'b10, 0, 0, 32'h90, 1, 0, 0, 0, 32'h90);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL release_pc got=%h exp=%h", current_pc, exp); end
    checks++; if (ras_empty !== 1'b0) begin failures++; $display("[TB] FAIL release_push got=%b exp=0", ras_empty); end
    cycle(2'b11, 0, 0, 32'h0, 0, 0, 0, 0, 32'h31);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL release_ret got=%h exp=%h", current_pc, exp); end
  endtask

  task automatic test_exception();
    cycle(2'b10, 0, 0, 32'h44, 0, 0, 0, 0, 32'h44);
    void'(expQ.pop_front());
    cycle(2'b10, 0, 0, 32'h99, 1, 1, 1, 0, 32'h40);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL exc_pc got=%h exp=%h", current_pc, exp); end
    checks++; if (epc !== 32'h44) begin failures++; $display("[TB] FAIL exc_epc got=%h exp=%h", epc, 32'h44); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL exc_ras got=%b exp=1", ras_empty); end
    cycle(2'b00, 0, 0, 32'h0, 0, 1, 0, 1, 32'h44);
    exp = expQ.pop_front();
    checks++; if (current_pc !== exp) begin failures++; $display("[TB] FAIL eret_pc got=%h exp=%h", current_pc, exp); end
    checks++; if (epc !== 32'h44) begin failures++; $display("[TB] FAIL eret_epc got=%h exp=%h", epc, 32'h44); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    clr_n = 1'b1;
    stall = 1'b0; pc_inc_type = 2'b00; branch_taken = 1'b0; branch_offset = '0;
    abs_addr = '0; is_call = 1'b0; exc_req = 1'b0; eret = 1'b0;
    @(posedge clk);
    test_reset();
    test_branch();
    test_call_return();
    test_ras_overflow();
    test_stall();
    test_exception();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the word-addressed MIPS core. Addresses ignore the low byte bits, so sequential fetch is PC+1.
- Adds the following to the basic next-PC selection (normal / branch / absolute jump):
  - a configurable reset vector
  - a fetch stall
  - a precise-exception redirect with EPC capture and ERET return
  - a circular return-address stack (RAS) that serves call/return pairs
- Feeds the instruction-memory address and the IF/ID pipeline register.

Parameters:
- ADDR_W, 32, PC and address width in bits.
- RESET_PC, 0, value loaded into current_pc at reset.
- EXC_VECTOR, 32'h0000_0040, target PC on exception.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on negedge clk.
- clr_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS; no state change this cycle.
- pc_inc_type  in  2  next-PC mode: 00 normal, 01 branch, 10 jump, 11 return.
- branch_taken  in  1  ALU branch result; used only when pc_inc_type=01.
- branch_offset  in  ADDR_W  signed word offset for branches.
- abs_addr  in  ADDR_W  absolute jump target; also the fallback target on return with an empty RAS.
- is_call  in  1  with pc_inc_type=10: push the return address (current_pc+1).
- exc_req  in  1  exception request.
- eret  in  1  return from exception.
- current_pc  out  ADDR_W  registered fetch PC.
- epc  out  ADDR_W  PC of the excepting instruction.
- ras_empty  out  1  RAS holds no entries.
- ras_overflow  out  1  sticky flag: a push overwrote the oldest entry.

Behaviour:
- Reset (clr_n=0, asynchronous, regardless of clk):
  - current_pc=RESET_PC, epc=0.
  - RAS count=0, top pointer=0, all entries 0.
  - ras_empty=1, ras_overflow=0.
- Per negedge, in strict priority order:
  1. exc_req: epc<=current_pc, current_pc<=EXC_VECTOR. RAS untouched. Overrides stall, eret and pc_inc_type.
  2. eret: current_pc<=epc. RAS untouched. Overrides stall.
  3. stall: all state held. No push or pop, even if is_call or type 11 is asserted.
  4. pc_inc_type=00: current_pc<=current_pc+1.
  5. pc_inc_type=01: current_pc<=current_pc+1+branch_offset if branch_taken, else current_pc+1.
  6. pc_inc_type=10: current_pc<=abs_addr. If is_call=1, also push current_pc+1.
  7. pc_inc_type=11, RAS non-empty: current_pc<=RAS top entry, then pop.
  8. pc_inc_type=11, RAS empty: current_pc<=abs_addr. No pop; count stays 0.
- Arithmetic: all sums are modulo 2^ADDR_W; branch_offset is two's complement. No overflow detection; wrap from all-ones to 0 is legal.
- RAS organisation:
  - Circular buffer of RAS_DEPTH entries with a top pointer of log2(RAS_DEPTH) bits and a count of 0..RAS_DEPTH.
  - Push: pointer+1 (wrapping), write the entry, count+1 saturating at RAS_DEPTH.
  - Push while full: overwrites the oldest entry (the pointer wraps onto it). Count stays RAS_DEPTH; ras_overflow<=1 and stays set until reset.
  - Pop: read the entry at the pointer, then pointer-1 (wrapping), count-1.
- is_call with pc_inc_type other than 10 is ignored.
- ras_empty is combinational from count==0. All other outputs are registered.
- Latency: a new PC appears one negedge after the selecting inputs. Inputs are sampled at that negedge only.

Decomposition:
- Add to defines.vh: PC_ADDR_RETURN (2'b11) alongside the existing PC_ADDR_NORMAL / PC_ADDR_BRANCH / PC_ADDR_JUMP codes, plus a default-exception-vector constant.
- One sub-module: pc_ras (parameters ADDR_W, RAS_DEPTH).
  - Ports: clk, clr_n, push, pop, push_data, top_data, empty, overflow.
  - Owns the pointer, count and storage.
- pc_unit owns next-PC selection, priority and EPC.

Test Plan:
- Reset vector: clr_n low mid-cycle with RESET_PC=32'h100 -> current_pc=32'h100 immediately, without waiting for a clock edge; 3 normal edges -> 32'h101, 32'h102, 32'h103.
- Branch: current_pc=32'h20, type 01, offset 32'hFFFF_FFFC:
  - branch_taken=1 -> 32'h1D.
  - branch_taken=0 -> 32'h21.
  - current_pc=32'hFFFF_FFFF, type 00 -> 32'h0 (wrap).
- Call/return: at 32'h10, type 10 with is_call=1 and abs_addr=32'h80 -> 32'h80, ras_empty=0. Type 11 -> 32'h11, ras_empty=1. Type 11 again with abs_addr=32'h55 -> 32'h55.
- RAS overflow (RAS_DEPTH=4): 5 nested calls from PCs A..E -> ras_overflow=1. 4 returns yield E+1, D+1, C+1, B+1, then ras_empty=1.
- Stall: stall=1 with type 10 and is_call=1 -> current_pc and RAS count unchanged. Release -> jump and push occur.
- Exception: at 32'h44, exc_req=1 together with stall=1 and type 10 -> current_pc=EXC_VECTOR, epc=32'h44, RAS unchanged. Then eret=1 -> current_pc=32'h44.
